xdma: RTL

XDMA -- requirements
Module: xdma

---
 rtl/xdma.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/xdma.sv
// ---------------------------------------------------------------------------
// xdma : register-programmed DMA engine moving words between a valid/ready
//        stream and a shared single-port RAM (controller has port priority).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xdma #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              ctrl_mem_sel,
  output logic              dma_sel,
  output logic              dma_we,
  output logic [ADDR_W-2:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out,
  output logic              busy,
  output logic              done
);

  localparam int WADDR_W = ADDR_W - 1;
  localparam logic [WADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]   LEN_ONE  = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_HOLD = 3'd4;

  localparam logic [1:0] REG_ADDR = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  logic [2:0]         state_q, state_d;
  logic [WADDR_W-1:0] start_addr_q, start_addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               dir_q, dir_d;
  logic [WADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic w_reg_wr;
  logic w_wr_fire;
  logic w_rd_req;
  logic w_unused;

  // Register writes are locked out for the whole transfer.
  assign w_reg_wr = sel && we && !busy_q;

  // RAM requests are masked during reset so an aborted transfer touches nothing.
  assign w_wr_fire = rst && (state_q == S_WR) && in_valid && !ctrl_mem_sel;
  assign w_rd_req  = rst && (state_q == S_RD_REQ) && !ctrl_mem_sel;

  assign in_ready    = rst && (state_q == S_WR) && !ctrl_mem_sel;
  assign dma_sel     = w_wr_fire || w_rd_req;
  assign dma_we      = w_wr_fire;
  assign dma_addr    = dma_sel ? cur_addr_q : '0;
  assign dma_data_in = w_wr_fire ? in_data : '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign w_unused = ^data_in;

  always_comb begin
    data_out = '0;
    case (addr)
      REG_ADDR: data_out[WADDR_W-1:0] = start_addr_q;
      REG_LEN:  data_out[LEN_W-1:0]   = len_q;
      REG_CTRL: data_out[2:0]         = {dir_q, done_q, busy_q};
      default:  data_out              = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    len_d        = len_q;
    dir_d        = dir_q;
    cur_addr_d   = cur_addr_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (w_reg_wr) begin
      case (addr)
        REG_ADDR: start_addr_d = data_in[WADDR_W-1:0];
        REG_LEN:  len_d        = data_in[LEN_W-1:0];
        REG_CTRL: dir_d        = data_in[1];
        default:  ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (w_reg_wr && (addr == REG_CTRL) && data_in[0]) begin
          if (len_q != '0) begin
            cur_addr_d = start_addr_q;
            cnt_d      = len_q;
            done_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = data_in[1] ? S_RD_REQ : S_WR;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_WR: begin
        if (w_wr_fire) begin
          cur_addr_d = cur_addr_q + ADDR_ONE;
          cnt_d      = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_RD_REQ: begin
        if (w_rd_req) begin
          state_d = S_RD_WAIT;
        end
      end

      // RAM read data is valid exactly one cycle after the request.
      S_RD_WAIT: begin
        out_data_d  = dma_data_out;
        out_valid_d = 1'b1;
        state_d     = S_RD_HOLD;
      end

      S_RD_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          cnt_d       = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      start_addr_q <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      cur_addr_q   <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      cur_addr_q   <= cur_addr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

`default_nettype wire
